// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
//   Shared definitions for the LC-3 memory arbiter slice:
//   - default bus widths and timeout limit
//   - FSM state encoding (plain localparam constants)
//   - grant-index type used by the round-robin arbiter and the FSM
package lc3_mem_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int TIMEOUT_DEF    = 15;

  // Width of the WAIT-state timeout counter.
  localparam int TMO_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // 0 = requester 0 (CPU), 1 = requester 1 (loader/DMA).
  typedef logic gnt_idx_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// lc3_mem_arbiter_if
//   Bundles every non-clock signal of the arbiter.
//   Requester 0 : p0_req, p0_we, p0_addr, p0_wdata -> p0_ack, p0_err
//   Requester 1 : p1_req, p1_we, p1_addr, p1_wdata -> p1_ack, p1_err
//   Shared      : rdata (valid while either ack is high), busy
//   RAM side    : mem_cs, mem_r_w, mem_addr, mem_wdata <- mem_ready, mem_rdata
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters plus RAM)
interface lc3_mem_arbiter_if
  import lc3_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_err;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_err;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  logic                  mem_cs;
  logic                  mem_r_w;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err,
    output rdata, busy,
    output mem_cs, mem_r_w, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err,
    input  rdata, busy,
    input  mem_cs, mem_r_w, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lc3_rr_arbiter.sv
// lc3_rr_arbiter
//   Two-way round-robin grant logic, purely combinational.
//   Ports:
//     req[1:0]   - request vector, bit i = requester i
//     last_grant - index granted most recently
//     grant      - winning index (meaningful only when valid)
//     valid      - at least one request present
//   A lone requester always wins; under contention the requester
//   that was not granted last wins.
module lc3_rr_arbiter
  import lc3_mem_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_idx_t   last_grant,
  output gnt_idx_t   grant,
  output logic       valid
);

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
//   Arbitrates two requesters (CPU and loader/DMA) onto a single RAM port.
//   Each access walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
//     IDLE  : sample requests, latch the winner's command
//     ISSUE : one-cycle chip-select pulse with the latched command
//     WAIT  : wait for mem_ready, or give up after TIMEOUT cycles
//     DONE  : one-cycle ack to the granted requester, with its err
//   Ports:
//     clk   - single clock, all state on posedge
//     reset - synchronous, active-high
//     bus   - lc3_mem_arbiter_if.slave (requesters, shared return, RAM side)
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  lc3_mem_arbiter_if.slave  bus
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_t                state_q;
  gnt_idx_t              gnt_q;
  gnt_idx_t              last_grant_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [TMO_W-1:0]      tmo_q;

  gnt_idx_t              rr_grant;
  logic                  rr_valid;
  logic [TMO_W-1:0]      tmo_inc;

  lc3_rr_arbiter u_rr (
    .req        ({bus.p1_req, bus.p0_req}),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  assign tmo_inc = tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;   // p0 wins the first contention after reset
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_valid) begin
            gnt_q        <= rr_grant;
            last_grant_q <= rr_grant;
            we_q         <= rr_grant ? bus.p1_we    : bus.p0_we;
            addr_q       <= rr_grant ? bus.p1_addr  : bus.p0_addr;
            wdata_q      <= rr_grant ? bus.p1_wdata : bus.p0_wdata;
            state_q      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end

        // The counter holds the number of completed WAIT cycles without
        // mem_ready; the access is abandoned when that count hits TIMEOUT.
        // A ready in the same cycle still wins over the timeout.
        ST_WAIT: begin
          if (bus.mem_ready) begin
            rdata_q <= we_q ? '0 : bus.mem_rdata;
            err_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (tmo_inc == TMO_LIMIT) begin
            tmo_q   <= tmo_inc;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state, so the RAM command is
  // only visible during ISSUE and only one ack can ever be high.
  logic in_issue;
  logic in_done;

  assign in_issue = (state_q == ST_ISSUE);
  assign in_done  = (state_q == ST_DONE);

  assign bus.mem_cs    = in_issue;
  assign bus.mem_r_w   = in_issue & we_q;
  assign bus.mem_addr  = in_issue ? addr_q  : '0;
  assign bus.mem_wdata = in_issue ? wdata_q : '0;

  assign bus.p0_ack = in_done & (gnt_q == 1'b0);
  assign bus.p1_ack = in_done & (gnt_q == 1'b1);
  assign bus.p0_err = bus.p0_ack & err_q;
  assign bus.p1_err = bus.p1_ack & err_q;

  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter
//   Directed bench for lc3_mem_arbiter with a small synchronous RAM model
//   that raises mem_ready one cycle after chip select. Inputs change and
//   outputs are sampled on the falling edge.
//   Cycle naming: the rising edge that samples a request in IDLE is the
//   sample edge; the following falling edges land in ISSUE, WAIT, DONE.
module tb_lc3_mem_arbiter;
  import lc3_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lc3_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  lc3_mem_arbiter #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16),
    .TIMEOUT    (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model with a backdoor preload port.
  logic [15:0] ram [0:65535];
  logic        ram_ready_q = 1'b0;
  logic [15:0] ram_rdata_q = 16'h0000;
  logic        ram_dead;
  logic        force_ready;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    ram_ready_q <= bus.mem_cs && !ram_dead;
    if (bus.mem_cs) begin
      if (bus.mem_r_w) ram[bus.mem_addr] <= bus.mem_wdata;
      ram_rdata_q <= ram[bus.mem_addr];
    end
  end

  assign bus.mem_ready = ram_ready_q | force_ready;
  assign bus.mem_rdata = ram_rdata_q;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.p0_req   = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req   = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    ram_dead     = 1'b0;
    force_ready  = 1'b0;
    bd_we        = 1'b0;
    bd_addr      = '0;
    bd_data      = '0;

    // Reset and preload RAM[0x3000] = 0x1234.
    tick();
    bd_we = 1'b1; bd_addr = 16'h3000; bd_data = 16'h1234;
    tick();
    bd_we = 1'b0;
    tick();
    check("rst_busy",    bus.busy,      0);
    check("rst_mem_cs",  bus.mem_cs,    0);
    check("rst_mem_r_w", bus.mem_r_w,   0);
    check("rst_addr",    bus.mem_addr,  0);
    check("rst_wdata",   bus.mem_wdata, 0);
    check("rst_rdata",   bus.rdata,     0);
    check("rst_acks",    {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
    reset = 1'b0;

    // Single read by p0 from 0x3000.
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h3000;
    tick();  // ISSUE
    check("rd_issue_cs",   bus.mem_cs,   1);
    check("rd_issue_addr", bus.mem_addr, 16'h3000);
    check("rd_issue_rw",   bus.mem_r_w,  0);
    check("rd_issue_busy", bus.busy,     1);
    bus.p0_req = 1'b0;  // dropping req after grant must not abort
    tick();  // WAIT
    check("rd_wait_cs",  bus.mem_cs, 0);
    check("rd_wait_ack", bus.p0_ack, 0);
    tick();  // DONE
    check("rd_done_p0_ack", bus.p0_ack, 1);
    check("rd_done_p1_ack", bus.p1_ack, 0);
    check("rd_done_rdata",  bus.rdata,  16'h1234);
    check("rd_done_err",    bus.p0_err, 0);
    tick();  // IDLE
    check("rd_idle_ack",  bus.p0_ack, 0);
    check("rd_idle_busy", bus.busy,   0);

    // p1 writes 0xBEEF to 0x4000, then reads it back.
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 16'h4000; bus.p1_wdata = 16'hBEEF;
    tick();  // ISSUE
    check("wr_issue_cs",    bus.mem_cs,    1);
    check("wr_issue_rw",    bus.mem_r_w,   1);
    check("wr_issue_addr",  bus.mem_addr,  16'h4000);
    check("wr_issue_wdata", bus.mem_wdata, 16'hBEEF);
    bus.p1_req = 1'b0;
    tick();  // WAIT
    check("wr_wait_rw", bus.mem_r_w, 0);
    tick();  // DONE
    check("wr_done_p1_ack", bus.p1_ack, 1);
    check("wr_done_p0_ack", bus.p0_ack, 0);
    check("wr_done_rdata",  bus.rdata,  0);
    check("wr_done_err",    bus.p1_err, 0);
    tick();  // IDLE
    bus.p1_req = 1'b1; bus.p1_we = 1'b0;
    tick();  // ISSUE
    check("rb_issue_rw", bus.mem_r_w, 0);
    check("rb_issue_cs", bus.mem_cs,  1);
    bus.p1_req = 1'b0;
    tick();  // WAIT
    tick();  // DONE
    check("rb_done_p1_ack", bus.p1_ack, 1);
    check("rb_done_rdata",  bus.rdata,  16'hBEEF);
    tick();  // IDLE

    // Continuous contention from reset: p0, p1, p0, p1, one ack every 4 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h3000;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 16'h4000;
    for (int k = 0; k < 4; k++) begin
      tick();  // ISSUE
      check($sformatf("ct%0d_addr", k), bus.mem_addr, (k % 2 == 0) ? 16'h3000 : 16'h4000);
      check($sformatf("ct%0d_issue_acks", k), {bus.p0_ack, bus.p1_ack}, 0);
      tick();  // WAIT
      check($sformatf("ct%0d_wait_acks", k), {bus.p0_ack, bus.p1_ack}, 0);
      tick();  // DONE
      check($sformatf("ct%0d_acks", k), {bus.p0_ack, bus.p1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("ct%0d_rdata", k), bus.rdata, (k % 2 == 0) ? 16'h1234 : 16'hBEEF);
      tick();  // IDLE
      check($sformatf("ct%0d_idle_busy", k), bus.busy, 0);
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;

    // Timeout: RAM never answers; a stray ready during ISSUE is ignored.
    ram_dead = 1'b1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h3000;
    tick();  // ISSUE
    check("to_issue_cs", bus.mem_cs, 1);
    bus.p0_req  = 1'b0;
    force_ready = 1'b1;
    tick();  // WAIT cycle 1
    force_ready = 1'b0;
    check("to_wait1_busy", bus.busy,   1);
    check("to_wait1_ack",  bus.p0_ack, 0);
    for (int i = 2; i <= 15; i++) begin
      tick();  // WAIT cycle i
      check($sformatf("to_wait%0d_ack", i), bus.p0_ack, 0);
    end
    tick();  // DONE
    check("to_done_ack",   bus.p0_ack, 1);
    check("to_done_err",   bus.p0_err, 1);
    check("to_done_rdata", bus.rdata,  0);
    tick();  // IDLE
    check("to_idle_busy", bus.busy,   0);
    check("to_idle_ack",  bus.p0_ack, 0);
    ram_dead = 1'b0;

    // Reset during WAIT of a p1 write: no ack, everything cleared.
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 16'h4000;
    tick();  // ISSUE
    bus.p1_req = 1'b0;
    tick();  // WAIT
    tick();  // DONE
    check("pre_rst_rdata", bus.rdata, 16'hBEEF);
    tick();  // IDLE
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 16'h4100; bus.p1_wdata = 16'h5555;
    tick();  // ISSUE
    bus.p1_req = 1'b0;
    tick();  // WAIT, RAM ready is high now
    check("mr_wait_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    check("mr_p1_ack", bus.p1_ack,   0);
    check("mr_busy",   bus.busy,     0);
    check("mr_cs",     bus.mem_cs,   0);
    check("mr_rdata",  bus.rdata,    0);
    check("mr_errs",   {bus.p0_err, bus.p1_err}, 0);
    check("mr_addr",   bus.mem_addr, 0);
    reset = 1'b0;
    tick();
    check("mr_after_p1_ack", bus.p1_ack, 0);
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h3000;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 16'h4000;
    tick();  // ISSUE
    check("mr_first_grant_addr", bus.mem_addr, 16'h3000);
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    tick();  // WAIT
    tick();  // DONE
    check("mr_first_grant_acks", {bus.p0_ack, bus.p1_ack}, 2'b10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
